// File: rtl/store_queue_ctrl.sv
// Store buffer between the MEM stage and the data-memory/MMIO write port.
// Decodes byte masks, lane-aligns data, queues stores in order and flags load hazards.
module store_queue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [2:0]               st_funct3,
    input  logic [31:0]              st_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [3:0]               mem_wmask,
    output logic [31:0]              mem_wdata,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   st_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } q_state_t;

    q_state_t          state_q, next_state;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;

    logic [29:0]       q_addr [DEPTH];
    logic [3:0]        q_mask [DEPTH];
    logic [31:0]       q_data [DEPTH];

    logic              req_legal;
    logic [3:0]        req_mask;
    logic [31:0]       req_data;
    logic              enq, deq;

    // Request decode: mask and replicated lane data for each store width.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_legal = 1'b0;
        req_mask  = 4'b0000;
        req_data  = st_data;
        case (st_funct3)
            F3_SB: begin
                req_legal = 1'b1;
                req_mask  = 4'b0001 << st_addr[1:0];
                req_data  = {4{st_data[7:0]}};
            end
            F3_SH: begin
                req_legal = ~st_addr[0];
                req_mask  = st_addr[1] ? 4'b1100 : 4'b0011;
                req_data  = {2{st_data[15:0]}};
            end
            F3_SW: begin
                req_legal = (st_addr[1:0] == 2'b00);
                req_mask  = 4'b1111;
                req_data  = st_data;
            end
            default: ;
        endcase
    end

    assign enq = st_valid && st_ready && req_legal;
    assign deq = mem_valid && mem_ready;

    always_comb begin
        count_next = count;
        if (enq && !deq)
            count_next = count + 1'b1;
        else if (!enq && deq)
            count_next = count - 1'b1;
    end

    // NOTE: the entry storage has no reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= st_addr[31:2];
            q_mask[wr_ptr] <= req_mask;
            q_data[wr_ptr] <= req_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            misalign <= st_valid && st_ready && !req_legal;
        end
    end

    // Queue-control FSM: state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_EMPTY;
        else
            state_q <= next_state;
    end

    // Queue-control FSM: next state tracks occupancy after this cycle's enqueue/dequeue.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_EMPTY: begin
                if (enq)
                    next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (count_next == FULL_CNT)
                    next_state = S_FULL;
                else if (count_next == '0)
                    next_state = S_EMPTY;
            end
            S_FULL: begin
                if (deq)
                    next_state = S_ACTIVE;
            end
            default: next_state = S_EMPTY;
        endcase
    end

    // Queue-control FSM: outputs. Head fields read as zero while the queue is empty.
    always_comb begin
        st_ready  = (state_q != S_FULL);
        mem_valid = (state_q != S_EMPTY);
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (mem_valid) begin
            mem_addr  = {q_addr[rd_ptr], 2'b00};
            mem_wmask = q_mask[rd_ptr];
            mem_wdata = q_data[rd_ptr];
        end
    end

    // Load hazard looks at stored entries only; an entry is live if it lies within count of rd_ptr.
    always_comb begin
        logic             hit;
        logic [PTR_W-1:0] offset;
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (q_addr[i] == ld_addr[31:2]))
                hit = 1'b1;
        end
        ld_hazard = ld_valid && hit;
    end

    assign st_count = count;

endmodule
